// File: rtl/mips_timer.sv
// mips_timer: memory-mapped countdown timer with one-shot/auto-reload modes and maskable irq.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   addr     byte address from bridge, only addr[3:2] decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 none)
//   we       write strobe, already range/byteen-qualified by the bridge
//   wd       write data
//   rd       combinational read data
//   irq      CTRL.IM & irq_flag
module mips_timer #(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CNT  = 2'd1;
    localparam logic [1:0] INT  = 2'd2;

    logic [3:0]         ctrl_q, ctrl_d;
    logic [COUNT_W-1:0] preset_q, preset_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               flag_q, flag_d;
    logic [1:0]         state_q, state_d;
    logic               wr_ctrl, wr_pre, en, reload;
    logic               unused_addr;

    assign unused_addr = ^{addr[31:4], addr[1:0]};
    assign wr_ctrl = we && addr[3:2] == 2'd0;
    assign wr_pre  = we && addr[3:2] == 2'd1;
    assign en      = ctrl_q[0];
    assign reload  = ctrl_q[2:1] == 2'b01;

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        // one-shot flag is sticky; auto-reload flag lasts only the cycle after INT
        flag_d   = (state_q == INT) ? 1'b1 : (reload ? 1'b0 : flag_q);
        case (state_q)
            IDLE: if (en) begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: if (!en) state_d = IDLE;
            else if (count_q > COUNT_W'(1)) count_d = count_q - COUNT_W'(1);
            else begin
                count_d = '0;
                state_d = INT;
            end
            INT: if (reload) begin
                count_d = preset_q;
                state_d = CNT;
            end else begin
                ctrl_d[0] = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // CPU writes override whatever the FSM decided for CTRL and the flag
        if (wr_ctrl) begin
            ctrl_d = wd[3:0];
            flag_d = 1'b0;
        end
        if (wr_pre) preset_d = wd[COUNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            state_q  <= IDLE;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            state_q  <= state_d;
        end
    end

    assign rd  = (addr[3:2] == 2'd0) ? {28'd0, ctrl_q} :
                 (addr[3:2] == 2'd1) ? 32'(preset_q) :
                 (addr[3:2] == 2'd2) ? 32'(count_q) : 32'd0;
    assign irq = ctrl_q[3] & flag_q;
endmodule

// File: tb/tb_mips_timer.sv
// tb_mips_timer: table vectors, hand corner sequences and a randomized reference-model check of mips_timer.
module tb_mips_timer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        irq;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ra;
        logic [31:0] erd;
        logic        eirq;
    } vec_t;
    vec_t tbl[15];

    mips_timer #(.COUNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .we(we), .wd(wd), .rd(rd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rd, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h4, 32'h3, 32'h4, 32'h3, 1'b0};
        tbl[1]  = '{1'b1, 32'h0, 32'h9, 32'h0, 32'h9, 1'b0};
        tbl[2]  = '{1'b0, 32'h0, 32'h0, 32'h8, 32'h3, 1'b0};
        tbl[3]  = '{1'b0, 32'h0, 32'h0, 32'h8, 32'h2, 1'b0};
        tbl[4]  = '{1'b0, 32'h0, 32'h0, 32'h8, 32'h1, 1'b0};
        tbl[5]  = '{1'b0, 32'h0, 32'h0, 32'h8, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h8, 1'b1};
        tbl[7]  = '{1'b1, 32'h8, 32'h55, 32'h8, 32'h0, 1'b1};
        tbl[8]  = '{1'b1, 32'hC, 32'h77, 32'hC, 32'h0, 1'b1};
        tbl[9]  = '{1'b1, 32'h0, 32'h8, 32'h0, 32'h8, 1'b0};
        tbl[10] = '{1'b1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hF, 1'b0};
        tbl[11] = '{1'b0, 32'h0, 32'h0, 32'h8, 32'h3, 1'b0};
        tbl[12] = '{1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b1, 32'h4, 32'hFFFFFFFF, 32'h4, 32'hFFFFFFFF, 1'b0};
        tbl[14] = '{1'b1, 32'h4, 32'h0, 32'h4, 32'h0, 1'b0};

        do_reset();
        rdchk("rst_ctrl", 32'h0, 32'h0);
        rdchk("rst_preset", 32'h4, 32'h0);
        rdchk("rst_count", 32'h8, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else step();
            rdchk($sformatf("tbl%0d_rd", i), tbl[i].ra, tbl[i].erd);
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].eirq));
        end

        // asynchronous reset while counting
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        for (int k = 1; k <= 6; k++) step();
        rdchk("async_pre", 32'h8, 32'd5);
        #1 reset_n = 1'b0;
        rdchk("async_count", 32'h8, 32'h0);
        rdchk("async_ctrl", 32'h0, 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // auto-reload with PRESET change mid-run
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'hB);
        for (int k = 1; k <= 6; k++) begin
            step();
            rdchk($sformatf("ar_cnt%0d", k), 32'h8, (k % 3 == 1) ? 32'd2 : (k % 3 == 2) ? 32'd1 : 32'd0);
            chk($sformatf("ar_irq%0d", k), 32'(irq), 32'(k == 4));
        end
        wr(32'h4, 32'd5);
        chk("ar_irq7", 32'(irq), 32'h1);
        rdchk("ar_cnt7", 32'h8, 32'd2);
        for (int k = 8; k <= 17; k++) begin
            step();
            chk($sformatf("ar_irq%0d", k), 32'(irq), 32'(k == 10 || k == 16));
            if (k == 10) rdchk("ar_cnt10", 32'h8, 32'd5);
        end

        // masked one-shot: flag sets silently, EN clears
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("mask_irq%0d", k), 32'(irq), 32'h0);
        end
        rdchk("mask_ctrl", 32'h0, 32'h0);
        wr(32'h0, 32'h8);
        chk("mask_late_im", 32'(irq), 32'h0);

        // disable mid-count freezes COUNT, re-enable reloads
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h9);
        for (int k = 1; k <= 5; k++) step();
        rdchk("dis_pre", 32'h8, 32'd6);
        wr(32'h0, 32'h8);
        addr = 32'h8;
        #1;
        begin
            logic [31:0] frz;
            frz = rd;
            chk("dis_frz_range", 32'(frz == 32'd5 || frz == 32'd6), 32'h1);
            for (int k = 0; k < 4; k++) begin
                step();
                rdchk($sformatf("dis_hold%0d", k), 32'h8, frz);
                chk($sformatf("dis_irq%0d", k), 32'(irq), 32'h0);
            end
        end
        wr(32'h0, 32'h9);
        step();
        rdchk("reen_count", 32'h8, 32'd10);

        // CTRL write colliding with INT in auto-reload
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'hB);
        for (int k = 1; k <= 3; k++) step();
        rdchk("col_pre", 32'h8, 32'd0);
        wr(32'h0, 32'h0);
        rdchk("col_ctrl", 32'h0, 32'h0);
        chk("col_irq", 32'(irq), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("col_irq%0d", k), 32'(irq), 32'h0);
            rdchk($sformatf("col_cnt%0d", k), 32'h8, 32'd2);
        end

        // randomized runs against a closed-form model of the countdown
        for (int r = 0; r < 30; r++) begin
            int p, pe, mode, im, per, j, ecnt;
            logic eirq;
            logic [31:0] ectrl, wctrl;
            p = (r == 0) ? 0 : $urandom_range(0, 7);
            mode = (r == 0) ? 0 : $urandom_range(0, 3);
            im = (r == 0) ? 1 : $urandom_range(0, 1);
            pe = (p < 1) ? 1 : p;
            per = pe + 1;
            wctrl = 32'((im << 3) | (mode << 1) | 1);
            do_reset();
            wr(32'h4, 32'(p));
            wr(32'h0, wctrl);
            for (int k = 1; k <= 20; k++) begin
                step();
                if (mode == 1) begin
                    j = ((k - 1) % per) + 1;
                    eirq = (im == 1) && k > 1 && ((k - 1) % per) == 0;
                    ectrl = wctrl;
                end else begin
                    j = (k <= per) ? k : per;
                    eirq = (im == 1) && k >= pe + 2;
                    ectrl = (k >= pe + 2) ? (wctrl & 32'hE) : wctrl;
                end
                ecnt = (p - (j - 1) > 0) ? p - (j - 1) : 0;
                rdchk($sformatf("rnd%0d_k%0d_cnt", r, k), 32'h8, 32'(ecnt));
                chk($sformatf("rnd%0d_k%0d_irq", r, k), 32'(irq), 32'(eirq));
                rdchk($sformatf("rnd%0d_k%0d_ctrl", r, k), 32'h0, ectrl);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
